// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control constants: stage/source indices and default per-source hazard masks.
// Constants only; no logic, no latency, no backpressure.
package pipe_ctrl_pkg;

    localparam int NSTAGE_DEF = 6;
    localparam int NREQ_DEF   = 8;

    localparam int STG_PC     = 0;
    localparam int STG_PRE_IF = 1;
    localparam int STG_IF_ID  = 2;
    localparam int STG_ID_EX  = 3;
    localparam int STG_EX_MEM = 4;
    localparam int STG_MEM_WB = 5;

    localparam int SRC_COMPRESS   = 0;
    localparam int SRC_LOAD_USE   = 1;
    localparam int SRC_MULDIV     = 2;
    localparam int SRC_JUMP       = 3;
    localparam int SRC_TRAP_CSR   = 4;
    localparam int SRC_TRAP_FLUSH = 5;
    localparam int SRC_RAM_IF     = 6;
    localparam int SRC_RAM_MEM    = 7;

    typedef logic [NSTAGE_DEF-1:0]          stage_vec_t;
    typedef logic [NREQ_DEF*NSTAGE_DEF-1:0] hz_mask_t;

    localparam stage_vec_t COMPRESS_STALL   = 6'b000011;
    localparam stage_vec_t COMPRESS_FLUSH   = 6'b000000;
    localparam stage_vec_t LOAD_USE_STALL   = 6'b000111;
    localparam stage_vec_t LOAD_USE_FLUSH   = 6'b001000;
    localparam stage_vec_t MULDIV_STALL     = 6'b000111;
    localparam stage_vec_t MULDIV_FLUSH     = 6'b010000;
    localparam stage_vec_t JUMP_STALL       = 6'b000010;
    localparam stage_vec_t JUMP_FLUSH       = 6'b001110;
    localparam stage_vec_t TRAP_CSR_STALL   = 6'b111111;
    localparam stage_vec_t TRAP_CSR_FLUSH   = 6'b001110;
    localparam stage_vec_t TRAP_FLUSH_STALL = 6'b000000;
    localparam stage_vec_t TRAP_FLUSH_FLUSH = 6'b011110;
    localparam stage_vec_t RAM_IF_STALL     = 6'b011101;
    localparam stage_vec_t RAM_IF_FLUSH     = 6'b000000;
    localparam stage_vec_t RAM_MEM_STALL    = 6'b011111;
    localparam stage_vec_t RAM_MEM_FLUSH    = 6'b100000;

    // Source r occupies slice [r*NSTAGE +: NSTAGE]; source 0 is the rightmost element.
    localparam hz_mask_t DEF_STALL_MASK = {RAM_MEM_STALL, RAM_IF_STALL, TRAP_FLUSH_STALL, TRAP_CSR_STALL,
                                           JUMP_STALL, MULDIV_STALL, LOAD_USE_STALL, COMPRESS_STALL};
    localparam hz_mask_t DEF_FLUSH_MASK = {RAM_MEM_FLUSH, RAM_IF_FLUSH, TRAP_FLUSH_FLUSH, TRAP_CSR_FLUSH,
                                           JUMP_FLUSH, MULDIV_FLUSH, LOAD_USE_FLUSH, COMPRESS_FLUSH};

endpackage

// File: rtl/hazard_prio_enc.sv
// Priority encoder: index of the highest set request bit plus an any-set flag.
// Purely combinational (zero latency); no backpressure.
module hazard_prio_enc #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          vld
);

    always_comb begin
        idx = '0;
        vld = |req;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_arbiter.sv
// Stall/flush arbiter: highest-index hazard wins, shadowed flushes deferred until their stage unstalls.
// Zero-latency comb path from req_i; post-reset flush window, sticky stall-hang watchdog; no backpressure.
module pipeline_hazard_arbiter
    import pipe_ctrl_pkg::*;
#(
    parameter int                         NSTAGE     = NSTAGE_DEF,
    parameter int                         NREQ       = NREQ_DEF,
    parameter logic [NREQ*NSTAGE-1:0]     STALL_MASK = DEF_STALL_MASK,
    parameter logic [NREQ*NSTAGE-1:0]     FLUSH_MASK = DEF_FLUSH_MASK,
    parameter int                         RST_FLUSH  = 2,
    parameter int                         WDOG_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_i,
    output logic [NSTAGE-1:0]        stall_o,
    output logic [NSTAGE-1:0]        flush_o,
    output logic [$clog2(NREQ)-1:0]  win_id_o,
    output logic                     win_vld_o,
    output logic                     hang_o,
    input  logic                     hang_clr_i
);

    localparam int                IW           = $clog2(NREQ);
    localparam logic [WDOG_W-1:0] WDOG_MAX     = '1;
    localparam logic [3:0]        RST_CNT_INIT = 4'(RST_FLUSH);

    logic [IW-1:0]     win_id;
    logic              win_vld;
    logic [NSTAGE-1:0] ws;
    logic [NSTAGE-1:0] wf;
    logic [NSTAGE-1:0] sf;
    logic [NSTAGE-1:0] pend_q;
    logic [NSTAGE-1:0] pend_d;
    logic [NSTAGE-1:0] flush_c;
    logic [NSTAGE-1:0] stall_c;
    logic [3:0]        rst_cnt_q;
    logic [WDOG_W-1:0] wdog_q;
    logic              hang_q;
    logic              in_win;

    hazard_prio_enc #(
        .N  (NREQ),
        .IW (IW)
    ) u_prio_enc (
        .req (req_i),
        .idx (win_id),
        .vld (win_vld)
    );

    assign in_win = (rst_cnt_q != 4'd0);

    // Winner masks, plus the union of flushes requested by every active loser.
    always_comb begin
        ws = '0;
        wf = '0;
        sf = '0;
        if (win_vld) begin
            ws = STALL_MASK[int'(win_id)*NSTAGE +: NSTAGE];
            wf = FLUSH_MASK[int'(win_id)*NSTAGE +: NSTAGE];
        end
        for (int r = 0; r < NREQ; r++) begin
            if (req_i[r] && (r != int'(win_id))) begin
                sf = sf | FLUSH_MASK[r*NSTAGE +: NSTAGE];
            end
        end
    end

    // Loser/pending flushes fire on unstalled stages and park on stalled ones;
    // a winner flush on a parked stage consumes the pending bit.
    always_comb begin
        flush_c = wf | ((pend_q | sf) & ~ws);
        stall_c = ws & ~flush_c;
        pend_d  = (pend_q | sf) & ws & ~wf;
    end

    always_comb begin
        stall_o   = stall_c;
        flush_o   = flush_c;
        win_id_o  = win_id;
        win_vld_o = win_vld;
        if (in_win) begin
            stall_o   = '0;
            flush_o   = '1;
            win_id_o  = '0;
            win_vld_o = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q    <= '0;
            rst_cnt_q <= RST_CNT_INIT;
        end else if (in_win) begin
            pend_q    <= '0;
            rst_cnt_q <= rst_cnt_q - 4'd1;
        end else begin
            pend_q    <= pend_d;
        end
    end

    // Counts consecutive PC stalls; flag raised on the edge the count reaches all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q <= '0;
            hang_q <= 1'b0;
        end else if (hang_clr_i) begin
            wdog_q <= '0;
            hang_q <= 1'b0;
        end else if (stall_o[0]) begin
            if (wdog_q != WDOG_MAX) begin
                wdog_q <= wdog_q + 1'b1;
            end
            if (wdog_q >= WDOG_MAX - 1'b1) begin
                hang_q <= 1'b1;
            end
        end else begin
            wdog_q <= '0;
        end
    end

    assign hang_o = hang_q;

endmodule

// File: tb/tb_pipeline_hazard_arbiter.sv
// Directed bench for pipeline_hazard_arbiter: hand-computed stall/flush/winner vectors per cycle.
// Inputs driven 1ns after posedge, outputs sampled on negedge.
module tb_pipeline_hazard_arbiter;
    import pipe_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req_i;
    logic       hang_clr_i;
    logic [5:0] stall_o;
    logic [5:0] flush_o;
    logic [2:0] win_id_o;
    logic       win_vld_o;
    logic       hang_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_arbiter #(
        .WDOG_W (4)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .stall_o    (stall_o),
        .flush_o    (flush_o),
        .win_id_o   (win_id_o),
        .win_vld_o  (win_vld_o),
        .hang_o     (hang_o),
        .hang_clr_i (hang_clr_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_arb(input string tag, input logic [5:0] st, input logic [5:0] fl,
                              input logic [2:0] id, input logic vld);
        @(negedge clk);
        chk({tag, ".stall"}, 32'(stall_o), 32'(st));
        chk({tag, ".flush"}, 32'(flush_o), 32'(fl));
        chk({tag, ".id"},    32'(win_id_o), 32'(id));
        chk({tag, ".vld"},   32'(win_vld_o), 32'(vld));
    endtask

    function automatic logic [7:0] src(input int s);
        logic [7:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst        = 1'b0;
        req_i      = '0;
        hang_clr_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 req_i = src(SRC_JUMP);
        expect_arb("in_rst", 6'b000000, 6'b111111, 3'd0, 1'b0);
        chk("in_rst.hang", 32'(hang_o), 32'd0);

        tick; rst = 1'b1; req_i = '0;
        expect_arb("win0", 6'b000000, 6'b111111, 3'd0, 1'b0);
        tick;
        expect_arb("win1", 6'b000000, 6'b111111, 3'd0, 1'b0);
        tick;
        expect_arb("idle", 6'b000000, 6'b000000, 3'd0, 1'b0);

        tick; req_i = src(SRC_JUMP);
        expect_arb("jump", 6'b000000, 6'b001110, 3'd3, 1'b1);
        tick; req_i = '0;
        expect_arb("jump_off", 6'b000000, 6'b000000, 3'd0, 1'b0);
        tick; req_i = src(SRC_LOAD_USE) | src(SRC_MULDIV);
        expect_arb("lu_md", 6'b000111, 6'b011000, 3'd2, 1'b1);
        tick; req_i = src(SRC_TRAP_CSR);
        expect_arb("trap_csr", 6'b110001, 6'b001110, 3'd4, 1'b1);
        tick; req_i = src(SRC_RAM_IF);
        expect_arb("ram_if", 6'b011101, 6'b000000, 3'd6, 1'b1);

        for (int k = 0; k < 3; k++) begin
            tick; req_i = src(SRC_RAM_MEM) | src(SRC_JUMP);
            expect_arb($sformatf("mem_jmp%0d", k), 6'b011111, 6'b100000, 3'd7, 1'b1);
        end
        tick; req_i = '0;
        expect_arb("defer_emit", 6'b000000, 6'b001110, 3'd0, 1'b0);
        tick;
        expect_arb("defer_once", 6'b000000, 6'b000000, 3'd0, 1'b0);

        tick; req_i = src(SRC_RAM_MEM) | src(SRC_JUMP);
        expect_arb("part_setup", 6'b011111, 6'b100000, 3'd7, 1'b1);
        tick; req_i = src(SRC_LOAD_USE);
        expect_arb("part_lu", 6'b000111, 6'b001000, 3'd1, 1'b1);
        tick; req_i = '0;
        expect_arb("part_rest", 6'b000000, 6'b000110, 3'd0, 1'b0);
        tick;
        expect_arb("part_done", 6'b000000, 6'b000000, 3'd0, 1'b0);

        tick; req_i = src(SRC_RAM_MEM) | src(SRC_JUMP);
        expect_arb("wf_setup", 6'b011111, 6'b100000, 3'd7, 1'b1);
        tick; req_i = src(SRC_TRAP_CSR);
        expect_arb("wf_trap", 6'b110001, 6'b001110, 3'd4, 1'b1);
        tick; req_i = '0;
        expect_arb("wf_clear", 6'b000000, 6'b000000, 3'd0, 1'b0);

        tick; req_i = src(SRC_RAM_MEM);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            chk($sformatf("wdog_run%0d", k), 32'(hang_o), 32'd0);
            tick;
        end
        @(negedge clk);
        chk("hang_set", 32'(hang_o), 32'd1);
        tick; req_i = '0;
        @(negedge clk);
        chk("hang_sticky", 32'(hang_o), 32'd1);
        tick; req_i = src(SRC_RAM_MEM); hang_clr_i = 1'b1;
        @(negedge clk);
        chk("hang_clr_cyc", 32'(hang_o), 32'd1);
        tick; hang_clr_i = 1'b0;
        @(negedge clk);
        chk("hang_cleared", 32'(hang_o), 32'd0);
        repeat (14) tick;
        @(negedge clk);
        chk("wdog_restart", 32'(hang_o), 32'd0);
        tick;
        @(negedge clk);
        chk("hang_again", 32'(hang_o), 32'd1);
        tick; req_i = '0; hang_clr_i = 1'b1;
        tick; hang_clr_i = 1'b0;
        @(negedge clk);
        chk("hang_final_clr", 32'(hang_o), 32'd0);

        tick; req_i = src(SRC_RAM_MEM) | src(SRC_JUMP);
        tick;
        #2 rst = 1'b0;
        #1;
        chk("async.flush", 32'(flush_o), 32'h3F);
        chk("async.stall", 32'(stall_o), 32'd0);
        chk("async.vld", 32'(win_vld_o), 32'd0);
        chk("async.hang", 32'(hang_o), 32'd0);
        tick;
        tick; rst = 1'b1; req_i = '0;
        expect_arb("rwin0", 6'b000000, 6'b111111, 3'd0, 1'b0);
        tick;
        expect_arb("rwin1", 6'b000000, 6'b111111, 3'd0, 1'b0);
        tick;
        expect_arb("no_stale", 6'b000000, 6'b000000, 3'd0, 1'b0);
        tick;
        expect_arb("no_stale2", 6'b000000, 6'b000000, 3'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
